// File: rtl/fir_pkg.sv
// Shared definitions for the FIR serializer/deserializer pair.
// One-hot FSM state encodings and the default parallel word width.
package fir_pkg;

  localparam int DEFAULT_LENGTH = 24;

  typedef enum logic [2:0] {
    IDLE  = 3'b001,
    LOAD  = 3'b010,
    SHIFT = 3'b100
  } state_t;

endpackage

// File: rtl/word_hold_reg.sv
// One-entry hold register: latency 1 cycle from accept to valid.
// Backpressure: ready drops while the entry is full, when disabled, or in reset.
module word_hold_reg
  import fir_pkg::*;
#(
  parameter int WIDTH = DEFAULT_LENGTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             ready,
  input  logic             drain,
  output logic [WIDTH-1:0] dout,
  output logic             valid
);

  assign ready = en & ~valid & ~rst;

  // A capture on the same edge as a drain wins, so the new word stays held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout  <= '0;
      valid <= 1'b0;
    end else if (en) begin
      if (din_valid && ready) begin
        dout  <= din;
        valid <= 1'b1;
      end else if (drain) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/serializer_fsm.sv
// Parallel-to-serial converter, LSB first: first bit valid 2 cycles after accept.
// Backpressure: i_ready=0 holds the current bit; o_ready=0 while a word is held.
module serializer_fsm
  import fir_pkg::*;
#(
  parameter int LENGTH = DEFAULT_LENGTH
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic [LENGTH-1:0] iv_din,
  input  logic              i_din_valid,
  output logic              o_ready,
  output logic              o_dout,
  output logic              o_dout_valid,
  input  logic              i_ready,
  output logic              o_last
);

  localparam int CW = $clog2(LENGTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(LENGTH - 1);

  state_t            state;
  logic [LENGTH-1:0] shift_reg;
  logic [CW-1:0]     counter;
  logic [LENGTH-1:0] hold_dat;
  logic              hold_valid;
  logic              drain;
  logic              bit_xfer;
  logic              at_last;

  word_hold_reg #(.WIDTH(LENGTH)) u_hold (
    .clk       (i_clk),
    .rst       (i_rst),
    .en        (i_en),
    .din       (iv_din),
    .din_valid (i_din_valid),
    .ready     (o_ready),
    .drain     (drain),
    .dout      (hold_dat),
    .valid     (hold_valid)
  );

  assign o_dout_valid = i_en & (state == SHIFT);
  assign bit_xfer     = o_dout_valid & i_ready;
  assign at_last      = (counter == LAST_CNT);
  assign o_last       = o_dout_valid & at_last;
  assign o_dout       = shift_reg[0];

  // The hold entry empties on LOAD exit or on a zero-bubble reload after the last bit.
  assign drain = i_en & ((state == LOAD) | (bit_xfer & at_last & hold_valid));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      counter   <= '0;
    end else if (i_en) begin
      case (state)
        IDLE: begin
          if (hold_valid) state <= LOAD;
        end
        LOAD: begin
          shift_reg <= hold_dat;
          counter   <= '0;
          state     <= SHIFT;
        end
        SHIFT: begin
          if (bit_xfer) begin
            if (at_last) begin
              counter <= '0;
              if (hold_valid) begin
                shift_reg <= hold_dat;
              end else begin
                shift_reg <= {1'b0, shift_reg[LENGTH-1:1]};
                state     <= IDLE;
              end
            end else begin
              shift_reg <= {1'b0, shift_reg[LENGTH-1:1]};
              counter   <= counter + 1'b1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          counter <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serializer_fsm.sv
// Directed bench for serializer_fsm with a word/bit-queue reference model.
module tb_serializer_fsm;

  localparam int LEN = 24;

  logic           clk = 1'b0;
  logic           rst;
  logic           en;
  logic [LEN-1:0] din;
  logic           din_valid;
  logic           rdy;
  logic           o_ready;
  logic           o_dout;
  logic           o_dout_valid;
  logic           o_last;

  int checks = 0;
  int errs   = 0;
  int cyc    = 0;

  // Reference model: expected serial bits and word bookkeeping since last reset.
  bit exp_q[$];
  int accepted = 0;
  int started  = 0;
  int popped   = 0;
  int widx;

  // Log of every bit transfer seen.
  bit got_bits[$];
  bit got_last[$];
  int got_cyc[$];

  serializer_fsm #(.LENGTH(LEN)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_en         (en),
    .iv_din       (din),
    .i_din_valid  (din_valid),
    .o_ready      (o_ready),
    .o_dout       (o_dout),
    .o_dout_valid (o_dout_valid),
    .i_ready      (rdy),
    .o_last       (o_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      accepted = 0;
      started  = 0;
      popped   = 0;
      chk("rst_ready", o_ready, 0);
      chk("rst_dout", o_dout, 0);
      chk("rst_valid", o_dout_valid, 0);
      chk("rst_last", o_last, 0);
    end else begin
      if (o_dout_valid) begin
        chk("valid_needs_en", en, 1);
        chk("bit_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          chk("dout", o_dout, exp_q[0]);
          chk("last", o_last, (popped % LEN) == LEN - 1);
          widx = popped / LEN;
          if (started < widx + 1) started = widx + 1;
        end
      end else begin
        chk("last_without_valid", o_last, 0);
      end
      chk("ready", o_ready, en && (accepted == started));
      if (en && din_valid && o_ready) begin
        for (int i = 0; i < LEN; i++) exp_q.push_back(din[i]);
        accepted++;
      end
      if (o_dout_valid && rdy && exp_q.size() != 0) begin
        got_bits.push_back(o_dout);
        got_last.push_back(o_last);
        got_cyc.push_back(cyc);
        void'(exp_q.pop_front());
        popped++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    got_bits.delete();
    got_last.delete();
    got_cyc.delete();
  endtask

  task automatic send_word(input logic [LEN-1:0] w, output int tries);
    bit acc = 0;
    din       = w;
    din_valid = 1'b1;
    tries     = 0;
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge clk);
      tries++;
      if (o_ready && en) acc = 1;
      @(posedge clk);
      #1;
    end
    din_valid = 1'b0;
    chk("send_accepted", acc, 1);
  endtask

  task automatic run_until(input int n, input bit toggle, input int budget);
    int k = 0;
    while (got_bits.size() < n && k < budget) begin
      @(posedge clk);
      #1;
      if (toggle) rdy = ~rdy;
      k++;
    end
    chk("bits_done", got_bits.size() >= n, 1);
  endtask

  function automatic logic [LEN-1:0] word_at(input int base);
    logic [LEN-1:0] r = '0;
    for (int i = 0; i < LEN; i++)
      if (base + i < got_bits.size()) r[i] = got_bits[base + i];
    return r;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int tries, n, lat, lastcnt, lastpos, gaps, ones;
    logic d;
    rst = 1'b1; en = 1'b1; din = '0; din_valid = 1'b0; rdy = 1'b1;
    repeat (3) tick();
    chk("reset_ready_literal", o_ready, 0);
    chk("reset_valid_literal", o_dout_valid, 0);
    rst = 1'b0;
    repeat (2) tick();
    chk("idle_ready", o_ready, 1);

    // Single word: latency, bit order, single o_last, back to idle.
    clear_log();
    send_word(24'hA5C30F, tries);
    n = cyc;
    lat = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (o_dout_valid) begin
        lat = cyc - n;
        break;
      end
    end
    chk("first_bit_latency", lat, 2);
    run_until(24, 1'b0, 100);
    chk("single_word", word_at(0), 24'hA5C30F);
    lastcnt = 0; lastpos = -1;
    foreach (got_last[i]) if (got_last[i]) begin lastcnt++; lastpos = i; end
    chk("single_last_count", lastcnt, 1);
    chk("single_last_pos", lastpos, 23);
    repeat (3) tick();
    @(negedge clk);
    chk("single_back_idle_valid", o_dout_valid, 0);
    chk("single_back_idle_ready", o_ready, 1);
    chk("single_exp_empty", exp_q.size(), 0);
    tick();

    // Back-to-back words with no bubble.
    clear_log();
    send_word(24'h000001, tries);
    send_word(24'h800000, tries);
    chk("b2b_second_tries", tries, 3);
    run_until(48, 1'b0, 200);
    gaps = 0; ones = 0;
    for (int i = 1; i < got_cyc.size(); i++) if (got_cyc[i] != got_cyc[i-1] + 1) gaps++;
    foreach (got_bits[i]) ones += got_bits[i];
    chk("b2b_gaps", gaps, 0);
    chk("b2b_ones", ones, 2);
    chk("b2b_bit0", got_bits[0], 1);
    chk("b2b_bit47", got_bits[47], 1);
    chk("b2b_word1", word_at(24), 24'h800000);
    repeat (4) tick();
    chk("b2b_exp_empty", exp_q.size(), 0);

    // Backpressure: sink alternates ready every cycle.
    clear_log();
    send_word(24'h3C5A96, tries);
    run_until(24, 1'b1, 200);
    rdy = 1'b1;
    chk("bp_word", word_at(0), 24'h3C5A96);
    chk("bp_span", got_cyc[23] - got_cyc[0], 46);
    repeat (4) tick();
    chk("bp_count", got_bits.size(), 24);

    // Enable freeze mid-word.
    clear_log();
    send_word(24'h123456, tries);
    run_until(8, 1'b0, 100);
    en = 1'b0;
    d = o_dout;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("frz_valid", o_dout_valid, 0);
      chk("frz_ready", o_ready, 0);
      chk("frz_dout", o_dout, d);
      tick();
    end
    chk("frz_count", got_bits.size(), 8);
    en = 1'b1;
    run_until(24, 1'b0, 100);
    chk("frz_word", word_at(0), 24'h123456);
    repeat (4) tick();

    // Asynchronous reset mid-word.
    clear_log();
    send_word(24'hFFFFFF, tries);
    run_until(10, 1'b0, 100);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_dout", o_dout, 0);
    chk("arst_valid", o_dout_valid, 0);
    chk("arst_ready", o_ready, 0);
    chk("arst_last", o_last, 0);
    @(posedge clk);
    tick();
    rst = 1'b0;
    clear_log();
    repeat (30) tick();
    chk("arst_no_bits", got_bits.size(), 0);
    chk("arst_idle_ready", o_ready, 1);

    // Second word arrives while the first is shifting.
    clear_log();
    send_word(24'h0F0F0F, tries);
    run_until(5, 1'b0, 100);
    send_word(24'hF0F0F0, tries);
    chk("hold_accept_tries", tries, 1);
    run_until(48, 1'b0, 200);
    chk("hold_word0", word_at(0), 24'h0F0F0F);
    chk("hold_word1", word_at(24), 24'hF0F0F0);
    repeat (4) tick();
    chk("hold_exp_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
